mult_bus_master: RTL and testbench

Bus initiator that drives the emulated GPIO peripheral's multiplier over its saddress/srd/swr/sdata register interface. It accepts a 24×24 multiply command on a valid/ready port and writes both operands and the start command. It then polls the status register until the operation is done, reads back the 32-bit product and the ones count, and returns them on a valid/ready response port. It is the CPU-side counterpart used by on-chip test logic and by the bench in place of software register accesses.

---
 rtl/mult_bus_master_if.sv | 25 ++
 rtl/mult_bus_master.sv | 145 ++++++++++++++
 tb/tb_mult_bus_master.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_bus_master_if.sv
// mult_bus_master_if: command/response handshake and srd/swr register bus of the multiplier bus master.
interface mult_bus_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [23:0] cmd_a1;
   logic [23:0] cmd_a2;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_product;
   logic [23:0] rsp_ones;
   logic        rsp_timeout;
   logic [15:0] saddress;
   logic        srd;
   logic        swr;
   logic [31:0] sdata_out;
   logic [31:0] sdata_in;
   modport master (
      input  cmd_valid, cmd_a1, cmd_a2, rsp_ready, sdata_in,
      output cmd_ready, rsp_valid, rsp_product, rsp_ones, rsp_timeout, saddress, srd, swr, sdata_out
   );
   modport slave (
      output cmd_valid, cmd_a1, cmd_a2, rsp_ready, sdata_in,
      input  cmd_ready, rsp_valid, rsp_product, rsp_ones, rsp_timeout, saddress, srd, swr, sdata_out
   );
endinterface

// File: rtl/mult_bus_master.sv
// mult_bus_master: loads multiplier operands over the srd/swr bus, starts it, polls status, returns the result.
// Define MULT_MASTER_ONES_EN to also read back the ones count; otherwise rsp_ones stays 0.
module mult_bus_master #(
   parameter int          STROBE_CYCLES = 1,
   parameter logic [15:0] POLL_LIMIT    = 16'd1000,
   parameter logic [15:0] ADDR_A1       = 16'h037F,
   parameter logic [15:0] ADDR_A2       = 16'h0388,
   parameter logic [15:0] ADDR_CTRL     = 16'h03A0,
   parameter logic [15:0] ADDR_RESULT   = 16'h0390,
   parameter logic [15:0] ADDR_ONES     = 16'h0398
) (
   input logic               clk,
   input logic               reset,
   mult_bus_master_if.master bus
);
   localparam int            S    = STROBE_CYCLES + 2;
   localparam int            CW   = $clog2(S + 1);
   localparam logic [CW-1:0] LAST = CW'(S - 1);
   localparam logic [CW-1:0] STRB = CW'(STROBE_CYCLES);
   typedef enum logic [2:0] {IDLE, WR_A1, WR_A2, WR_START, POLL, RD_RESULT, RD_ONES, RESP} state_t;
   state_t        r_state, w_state_n;
   logic [CW-1:0] r_cnt, w_cnt_n;
   logic [15:0]   r_poll, w_poll_n, w_poll_inc;
   logic [23:0]   r_a2, w_a2_n;
   logic [15:0]   r_saddress, w_saddress_n;
   logic [31:0]   r_sdata_out, w_sdata_out_n;
   logic          r_srd, w_srd_n, r_swr, w_swr_n;
   logic          r_cmd_ready, w_cmd_ready_n;
   logic          r_rsp_valid, w_rsp_valid_n;
   logic          r_rsp_timeout, w_rsp_timeout_n;
   logic [31:0]   r_rsp_product, w_rsp_product_n;
   logic [23:0]   r_rsp_ones, w_rsp_ones_n;
   logic          w_end, w_bus, w_rd, w_strobe;
   // Every output is computed from the next state and registered, so nothing reaches a port combinationally.
   always_comb begin
      w_state_n       = r_state;
      w_poll_n        = r_poll;
      w_a2_n          = r_a2;
      w_sdata_out_n   = r_sdata_out;
      w_rsp_timeout_n = r_rsp_timeout;
      w_rsp_product_n = r_rsp_product;
      w_rsp_ones_n    = r_rsp_ones;
      w_end           = (r_cnt == LAST);
      w_poll_inc      = r_poll + 16'd1;
      w_cnt_n         = (w_end || r_state == IDLE || r_state == RESP) ? '0 : r_cnt + CW'(1);
      case (r_state)
         IDLE: if (bus.cmd_valid) begin
            w_state_n       = WR_A1;
            w_poll_n        = '0;
            w_a2_n          = bus.cmd_a2;
            w_sdata_out_n   = {8'h0, bus.cmd_a1};
            w_rsp_timeout_n = 1'b0;
            w_rsp_product_n = '0;
            w_rsp_ones_n    = '0;
         end
         WR_A1: if (w_end) begin
            w_state_n     = WR_A2;
            w_sdata_out_n = {8'h0, r_a2};
         end
         WR_A2: if (w_end) begin
            w_state_n     = WR_START;
            w_sdata_out_n = '0;
         end
         WR_START: if (w_end) w_state_n = POLL;
         POLL: if (w_end) begin
            if (bus.sdata_in[1:0] == 2'b11) w_state_n = RD_RESULT;
            else begin
               w_poll_n = w_poll_inc;
               if (w_poll_inc == POLL_LIMIT) begin
                  w_state_n       = RESP;
                  w_rsp_timeout_n = 1'b1;
               end
            end
         end
         RD_RESULT: if (w_end) begin
            w_rsp_product_n = bus.sdata_in;
`ifdef MULT_MASTER_ONES_EN
            w_state_n       = RD_ONES;
`else
            w_state_n       = RESP;
`endif
         end
`ifdef MULT_MASTER_ONES_EN
         RD_ONES: if (w_end) begin
            w_rsp_ones_n = bus.sdata_in[23:0];
            w_state_n    = RESP;
         end
`endif
         RESP: if (bus.rsp_ready) w_state_n = IDLE;
         default: ;
      endcase
      w_bus         = !(w_state_n inside {IDLE, RESP});
      w_rd          = w_state_n inside {POLL, RD_RESULT, RD_ONES};
      w_strobe      = w_bus && (w_cnt_n != '0) && (w_cnt_n <= STRB);
      w_srd_n       = w_strobe && w_rd;
      w_swr_n       = w_strobe && !w_rd;
      w_saddress_n  = w_state_n == WR_A1 ? ADDR_A1 :
                      w_state_n == WR_A2 ? ADDR_A2 :
                      w_state_n inside {WR_START, POLL} ? ADDR_CTRL :
                      w_state_n == RD_RESULT ? ADDR_RESULT :
                      w_state_n == RD_ONES ? ADDR_ONES : r_saddress;
      w_rsp_valid_n = (w_state_n == RESP);
      w_cmd_ready_n = (w_state_n == IDLE);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_poll        <= '0;
         r_a2          <= '0;
         r_saddress    <= '0;
         r_sdata_out   <= '0;
         r_srd         <= 1'b0;
         r_swr         <= 1'b0;
         r_cmd_ready   <= 1'b1;
         r_rsp_valid   <= 1'b0;
         r_rsp_timeout <= 1'b0;
         r_rsp_product <= '0;
         r_rsp_ones    <= '0;
      end else begin
         r_state       <= w_state_n;
         r_cnt         <= w_cnt_n;
         r_poll        <= w_poll_n;
         r_a2          <= w_a2_n;
         r_saddress    <= w_saddress_n;
         r_sdata_out   <= w_sdata_out_n;
         r_srd         <= w_srd_n;
         r_swr         <= w_swr_n;
         r_cmd_ready   <= w_cmd_ready_n;
         r_rsp_valid   <= w_rsp_valid_n;
         r_rsp_timeout <= w_rsp_timeout_n;
         r_rsp_product <= w_rsp_product_n;
         r_rsp_ones    <= w_rsp_ones_n;
      end
   end
   assign bus.cmd_ready   = r_cmd_ready;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_timeout = r_rsp_timeout;
   assign bus.rsp_product = r_rsp_product;
   assign bus.rsp_ones    = r_rsp_ones;
   assign bus.saddress    = r_saddress;
   assign bus.srd         = r_srd;
   assign bus.swr         = r_swr;
   assign bus.sdata_out   = r_sdata_out;
endmodule

// File: tb/tb_mult_bus_master.sv
// tb_mult_bus_master: two masters (strobe 1 and 3, poll limit 4) against a behavioural multiplier responder.
module tb_mult_bus_master;
   localparam int PL = 4;
`ifdef MULT_MASTER_ONES_EN
   localparam int NRD = 5;
   localparam bit ONES = 1'b1;
`else
   localparam int NRD = 4;
   localparam bit ONES = 1'b0;
`endif
   typedef struct {
      logic [23:0] a1, a2;
      int          k, hold;
      logic [31:0] prod;
      logic [23:0] ones;
      logic        to;
      int          lat;
   } vec_t;
   logic clk = 0, reset = 0;
   int cyc = 0, errors = 0, checks = 0;
   logic cv [2], rr [2];
   logic [23:0] ca1 [2], ca2 [2];
   int done_k [2];
   wire rdy [2], vld [2], tmo [2], srd [2], swr [2];
   wire [31:0] prd [2], sdo [2];
   wire [23:0] ones [2];
   wire [15:0] addr [2];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic int bad(input string n, input int g, input longint a, input longint x);
      if (a != x) $display("FAIL mon_%s[%0d]: got %0d expected %0d", n, g, a, x);
      return (a != x) ? 1 : 0;
   endfunction
   for (genvar g = 0; g < 2; g++) begin : u
      localparam int SC = (g == 0) ? 1 : 3;
      mult_bus_master_if ifc ();
      mult_bus_master #(.STROBE_CYCLES(SC), .POLL_LIMIT(16'(PL))) dut (.clk(clk), .reset(reset), .bus(ifc.master));
      logic [31:0] sdi = 0;
      logic [23:0] m_a1 = 0, m_a2 = 0;
      logic [47:0] prod;
      logic [47:0] wl [3];
      int nw = 0, np = 0, w = 0, last = -1, me = 0, mc = 0;
      logic p_rd = 0, p_wr = 0, ps = 0;
      logic [15:0] pa = 0;
      assign ifc.cmd_valid = cv[g];
      assign ifc.cmd_a1    = ca1[g];
      assign ifc.cmd_a2    = ca2[g];
      assign ifc.rsp_ready = rr[g];
      assign ifc.sdata_in  = sdi;
      assign rdy[g]  = ifc.cmd_ready;
      assign vld[g]  = ifc.rsp_valid;
      assign tmo[g]  = ifc.rsp_timeout;
      assign prd[g]  = ifc.rsp_product;
      assign ones[g] = ifc.rsp_ones;
      assign addr[g] = ifc.saddress;
      assign srd[g]  = ifc.srd;
      assign swr[g]  = ifc.swr;
      assign sdo[g]  = ifc.sdata_out;
      assign prod = 48'(m_a1) * 48'(m_a2);
      // responder: acts on strobe rising edges, status upper bits and ones upper bits carry junk
      always @(negedge clk) begin
         p_rd <= ifc.srd;
         p_wr <= ifc.swr;
         if (ifc.swr && !p_wr) begin
            if (ifc.saddress == 16'h037F) begin
               nw <= 1;
               wl[0] <= {ifc.saddress, ifc.sdata_out};
               m_a1 <= ifc.sdata_out[23:0];
            end else begin
               if (nw < 3) wl[nw] <= {ifc.saddress, ifc.sdata_out};
               nw <= nw + 1;
            end
            if (ifc.saddress == 16'h0388) m_a2 <= ifc.sdata_out[23:0];
            if (ifc.saddress == 16'h03A0) np <= 0;
         end
         if (ifc.srd && !p_rd) begin
            if (ifc.saddress == 16'h03A0) begin
               np  <= np + 1;
               sdi <= (done_k[g] != 0 && np + 1 >= done_k[g]) ? 32'h5A5A5A53 : 32'hA5A5A5A1;
            end else if (ifc.saddress == 16'h0390) sdi <= prod[31:0];
            else if (ifc.saddress == 16'h0398) sdi <= {8'hC3, 24'($countones(prod[31:0]))};
            else sdi <= 32'hDEADBEEF;
         end
      end
      // bus monitor: strobe width, access spacing, address stability around strobes
      always @(negedge clk) begin
         int e, c;
         e = 0;
         c = 0;
         if (!reset && (ifc.srd || ifc.swr) && !ps) begin
            c = 2 + ((last >= 0) ? 1 : 0);
            e = bad("one_strobe", g, longint'(ifc.srd & ifc.swr), 0) + bad("addr_setup", g, ifc.saddress, pa)
              + ((last >= 0) ? bad("access_len", g, cyc - last, SC + 2) : 0);
         end
         if (!reset && !(ifc.srd || ifc.swr) && ps) begin
            c = 2;
            e = bad("strobe_len", g, w, SC) + bad("addr_hold", g, ifc.saddress, pa);
         end
         me   <= me + e;
         mc   <= mc + c;
         w    <= (reset || !(ifc.srd || ifc.swr)) ? 0 : w + 1;
         last <= (reset || ifc.cmd_ready) ? -1 : ((ifc.srd || ifc.swr) && !ps) ? cyc : last;
         pa   <= ifc.saddress;
         ps   <= !reset && (ifc.srd || ifc.swr);
      end
   end
   function automatic logic [47:0] wlg(input int g, input int i);
      return (g == 0) ? u[0].wl[i] : u[1].wl[i];
   endfunction
   function automatic int nwg(input int g);
      return (g == 0) ? u[0].nw : u[1].nw;
   endfunction
   function automatic int npg(input int g);
      return (g == 0) ? u[0].np : u[1].np;
   endfunction
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, x);
      end
   endtask
   task automatic run_cmd(input int g, input logic [23:0] a1, input logic [23:0] a2, input int k, input int hold,
                          input logic [31:0] ep, input logic [23:0] eo, input logic et, input int el);
      int t0, n;
      done_k[g] = k;
      @(negedge clk);
      chk("idle_ready", rdy[g], 1);
      cv[g] = 1;
      ca1[g] = a1;
      ca2[g] = a2;
      rr[g] = (hold == 0);
      @(negedge clk);
      cv[g] = 0;
      t0 = cyc;
      chk("busy_ready", rdy[g], 0);
      n = 0;
      while (!vld[g] && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("rsp_valid", vld[g], 1);
      chk("latency", 64'(cyc - t0), 64'(el));
      chk("product", prd[g], ep);
      chk("ones", ones[g], eo);
      chk("timeout", tmo[g], et);
      chk("writes", 64'(nwg(g)), 3);
      chk("wr_a1", wlg(g, 0), {16'h037F, 8'h0, a1});
      chk("wr_a2", wlg(g, 1), {16'h0388, 8'h0, a2});
      chk("wr_start", wlg(g, 2), {16'h03A0, 32'h0});
      chk("polls", 64'(npg(g)), 64'(et ? PL : k));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         cv[g] = (i == 3);
         ca1[g] = 24'h5;
         chk("hold_stable", {vld[g], rdy[g], tmo[g], ones[g], prd[g]}, {1'b1, 1'b0, et, eo, ep});
      end
      cv[g] = 0;
      rr[g] = 1;
      @(negedge clk);
      chk("rsp_done", vld[g], 0);
      chk("back_idle", rdy[g], 1);
      rr[g] = 0;
      if (hold > 0) begin
         repeat (3) @(negedge clk);
         chk("ignored_cmd", 64'(nwg(g)), 3);
      end
   endtask
   initial begin
      vec_t vt [4];
      logic [23:0] a1, a2;
      logic [47:0] p;
      logic [31:0] ep;
      logic [23:0] eo;
      logic et;
      int k, n, seen, sc;
      vt[0] = '{24'd3, 24'd5, 2, 0, 32'd15, ONES ? 24'd4 : 24'd0, 1'b0, ONES ? 21 : 18};
      vt[1] = '{24'hFFFFFF, 24'hFFFFFF, 1, 0, 32'hFE000001, ONES ? 24'd8 : 24'd0, 1'b0, ONES ? 18 : 15};
      vt[2] = '{24'd7, 24'd9, 0, 0, 32'd0, 24'd0, 1'b1, 21};
      vt[3] = '{24'h000100, 24'h000101, 4, 10, 32'h00010100, ONES ? 24'd2 : 24'd0, 1'b0, ONES ? 27 : 24};
      for (int g = 0; g < 2; g++) begin
         cv[g] = 0;
         rr[g] = 0;
         ca1[g] = 0;
         ca2[g] = 0;
         done_k[g] = 0;
      end
      reset = 1;
      #1;
      for (int g = 0; g < 2; g++) begin
         chk("rst_bus", {addr[g], srd[g], swr[g], sdo[g]}, 64'h0);
         chk("rst_rsp", {vld[g], tmo[g], ones[g], prd[g]}, 64'h0);
         chk("rst_ready", rdy[g], 1);
      end
      repeat (2) @(negedge clk);
      reset = 0;
      for (int i = 0; i < 4; i++)
         run_cmd(0, vt[i].a1, vt[i].a2, vt[i].k, vt[i].hold, vt[i].prod, vt[i].ones, vt[i].to, vt[i].lat);
      for (int i = 0; i < 10; i++) begin
         n = (i < 6) ? 0 : 1;
         sc = (n == 0) ? 1 : 3;
         a1 = 24'($urandom);
         a2 = (i == 9) ? 24'h0 : 24'($urandom);
         k = $urandom_range(0, PL);
         p = 48'(a1) * 48'(a2);
         et = (k == 0);
         ep = et ? 32'h0 : p[31:0];
         eo = (et || !ONES) ? 24'h0 : 24'($countones(p[31:0]));
         run_cmd(n, a1, a2, k, 0, ep, eo, et, (et ? 3 + PL : NRD + k) * (sc + 2));
      end
      done_k[0] = 2;
      @(negedge clk);
      cv[0] = 1;
      ca1[0] = 24'h11;
      ca2[0] = 24'h22;
      @(negedge clk);
      cv[0] = 0;
      n = 0;
      while (!(swr[0] && addr[0] == 16'h0388) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("reach_wr_a2", {swr[0], addr[0]}, {1'b1, 16'h0388});
      #2 reset = 1;
      #1;
      chk("abort_bus", {addr[0], srd[0], swr[0]}, 64'h0);
      chk("abort_ready", rdy[0], 1);
      repeat (2) @(negedge clk);
      #2 reset = 0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         seen = seen | vld[0] | srd[0] | swr[0];
      end
      chk("no_rsp_after_abort", seen, 0);
      chk("ready_after_abort", rdy[0], 1);
      run_cmd(0, vt[0].a1, vt[0].a2, vt[0].k, 0, vt[0].prod, vt[0].ones, vt[0].to, vt[0].lat);
      @(negedge clk);
      errors = errors + u[0].me + u[1].me;
      checks = checks + u[0].mc + u[1].mc;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end
endmodule
